pipe_result_monitor: RTL and testbench
======================================

# pipe_result_monitor

Synthesizable result monitor that sits on the far side of the `pipelined_top` `alu_out` port. It plays the role the bench stimulus cannot: it observes the result stream rather than driving the core. After reset and a pipeline-fill window, it compresses every change of `alu_out` into a 32-bit MISR signature. It declares completion when the stream has been quiet for a set number of cycles, or timeout when a cycle budget is exhausted, and compares the final signature against a golden value.

## Interface
Parameters:
- `WARMUP`, default 5: cycles ignored after reset or `clear` while the pipeline fills; must be ≥1.
- `STABLE_CYCLES`, default 8: consecutive unchanged `alu_out` cycles that mean the program has finished; must be ≥1.
- `MAX_CYCLES`, default 1000: RUN-cycle budget before timeout; must be ≤65535.
- `GOLDEN_SIG`, default 32'h0000_0000: expected final signature.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous restart into WARMUP.
- `alu_out`  in  32  result bus from the core.
- `signature`  out  32  current MISR value.
- `change_count`  out  16  number of hashed changes; saturates at 16'hFFFF.
- `cycle_count`  out  16  number of RUN cycles elapsed.
- `done`  out  1  quiet-completion flag; sticky.
- `timeout`  out  1  budget-exhausted flag; sticky.
- `match`  out  1  `signature == GOLDEN_SIG`, sampled on entry to DONE; sticky.

## Operation
- All outputs are registered. Internal state: `state`, `last_alu[31:0]`, `warm_cnt`, `stable_cnt`.
- Reset values (`rst_n` low, asynchronous):
  - state = WARMUP
  - `signature` = 32'hFFFF_FFFF
  - `last_alu`, `change_count`, `cycle_count`, `warm_cnt`, `stable_cnt` = 0
  - `done`, `timeout`, `match` = 0
- `last_alu <= alu_out` on every edge in every state.
- WARMUP:
  - `warm_cnt` increments each edge.
  - On the edge where `warm_cnt == WARMUP-1`, go to RUN.
  - No hashing or counting occurs in WARMUP.
- RUN, on each edge:
  - `cycle_count` increments.
  - If `alu_out != last_alu`, this is a change:
    - `fb = s[31]^s[21]^s[1]^s[0]`
    - `signature <= {s[30:0], fb} ^ alu_out`
    - `change_count` increments (saturating).
    - `stable_cnt <= 0`.
  - Otherwise `stable_cnt` increments.
  - Quiet exit: if there is no change and `stable_cnt == STABLE_CYCLES-1`, go to DONE, set `done <= 1`, and set `match <= (signature == GOLDEN_SIG)`. The signature compared is the current one; no update happens on this edge.
  - Else, if `cycle_count == MAX_CYCLES-1`, go to TIMEOUT and set `timeout <= 1`.
  - If both conditions hold on the same edge, DONE wins.
- DONE and TIMEOUT:
  - Terminal states; all outputs are frozen except internal `last_alu`.
  - Exit only via `clear` or `rst_n`.
- `clear` (any state):
  - Next state is WARMUP.
  - `signature`, the counters and the flags return to their reset values.
  - `clear` has priority over every RUN action on that edge.
- Reset mid-RUN aborts immediately. No partial signature survives.

## Timing
- The first hashed edge is edge WARMUP+1 after `rst_n` rises. The comparison on that edge is against the last warmup sample.
- Signature latency: one edge. A change seen at edge *n* is visible on `signature` after edge *n*.
- Minimum time to `done` from RUN entry: STABLE_CYCLES edges with a constant bus.
- `timeout` asserts after exactly MAX_CYCLES RUN edges if the bus never stays quiet long enough.
- `cycle_count` stops advancing in DONE and TIMEOUT.

## Test plan
1. Reset values: hold `rst_n` low with `alu_out` toggling → `signature`=FFFF_FFFF, all counts 0, all flags 0; de-assert and confirm no hashing for 5 edges.
2. Two changes from seed: defaults, bus is 0 during warmup, then 1 for one RUN edge, then 2 for one RUN edge.
   - Expected `signature`: FFFF_FFFF then FFFF_FFFC.
   - Expected `change_count`: 2.
3. Quiet completion: continue scenario 2 by holding 2.
   - Expected: `done`=1 after 8 more edges.
   - Expected: `match`=0 with GOLDEN_SIG=0, and `match`=1 when the bench sets GOLDEN_SIG=32'hFFFF_FFFC.
4. Timeout: MAX_CYCLES=20, bus toggles every edge.
   - Expected: `timeout`=1 and `cycle_count`=20 after 20 RUN edges; `done` stays 0.
   - Expected: flags and counts frozen for 10 further edges.
5. Simultaneous exit: MAX_CYCLES=12, STABLE_CYCLES=8, 4 changes then constant → quiet exit and budget coincide on RUN edge 12; expect `done`=1 and `timeout`=0.
6. Abort and restart:
   - Pulse `rst_n` low asynchronously mid-RUN (between edges) → immediate return to reset values.
   - Pulse `clear` in DONE → WARMUP, then a repeat of scenario 2 gives the same FFFF_FFFC signature.

Source files
------------

// File: rtl/pipe_result_monitor.sv
// Result-stream monitor: after a warmup window it folds every change of alu_out
// into a 32-bit MISR and flags quiet completion (with golden compare) or timeout.
module pipe_result_monitor #(
  parameter int          WARMUP        = 5,
  parameter int          STABLE_CYCLES = 8,
  parameter int          MAX_CYCLES    = 1000,
  parameter logic [31:0] GOLDEN_SIG    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [31:0] alu_out,
  output logic [31:0] signature,
  output logic [15:0] change_count,
  output logic [15:0] cycle_count,
  output logic        done,
  output logic        timeout,
  output logic        match
);

  localparam logic [1:0] S_WARMUP  = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;
  localparam logic [1:0] S_TIMEOUT = 2'd3;

  localparam logic [15:0] WARM_LAST   = 16'(WARMUP - 1);
  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [15:0] CYCLE_LAST  = 16'(MAX_CYCLES - 1);

  logic [1:0]  state;
  logic [31:0] last_alu;
  logic [15:0] warm_cnt;
  logic [15:0] stable_cnt;
  logic        changed;

  // Taps 31, 21, 1, 0 shifted into bit 0, then the new bus value is folded in.
  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] d);
    logic fb;
    fb = s[31] ^ s[21] ^ s[1] ^ s[0];
    return {s[30:0], fb} ^ d;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign changed = (alu_out != last_alu);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_WARMUP;
      signature    <= 32'hFFFF_FFFF;
      last_alu     <= '0;
      change_count <= '0;
      cycle_count  <= '0;
      warm_cnt     <= '0;
      stable_cnt   <= '0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      match        <= 1'b0;
    end else begin
      last_alu <= alu_out;
      if (clear) begin
        state        <= S_WARMUP;
        signature    <= 32'hFFFF_FFFF;
        change_count <= '0;
        cycle_count  <= '0;
        warm_cnt     <= '0;
        stable_cnt   <= '0;
        done         <= 1'b0;
        timeout      <= 1'b0;
        match        <= 1'b0;
      end else begin
        case (state)
          S_WARMUP: begin
            warm_cnt <= warm_cnt + 16'd1;
            if (warm_cnt == WARM_LAST) state <= S_RUN;
          end
          S_RUN: begin
            cycle_count <= cycle_count + 16'd1;
            if (changed) begin
              signature    <= misr_step(signature, alu_out);
              change_count <= sat_inc(change_count);
              stable_cnt   <= '0;
            end else begin
              stable_cnt <= stable_cnt + 16'd1;
            end
            // Quiet completion takes precedence over an exhausted budget.
            if (!changed && stable_cnt == STABLE_LAST) begin
              state <= S_DONE;
              done  <= 1'b1;
              match <= (signature == GOLDEN_SIG);
            end else if (cycle_count == CYCLE_LAST) begin
              state   <= S_TIMEOUT;
              timeout <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_result_monitor.sv
// Bench for pipe_result_monitor: directed table, timeout/coincidence sequences,
// abort/restart, and randomized traffic against a behavioural model.
module tb_pipe_result_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] alu_a = '0, alu_b = '0, alu_c = '0, alu_r = '0;

  logic [31:0] sig_d, sig_g, sig_t, sig_s, sig_r;
  logic [15:0] chg_d, chg_g, chg_t, chg_s, chg_r;
  logic [15:0] cyc_d, cyc_g, cyc_t, cyc_s, cyc_r;
  logic        dn_d, dn_g, dn_t, dn_s, dn_r;
  logic        to_d, to_g, to_t, to_s, to_r;
  logic        mt_d, mt_g, mt_t, mt_s, mt_r;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_result_monitor u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .alu_out(alu_a), .signature(sig_d),
    .change_count(chg_d), .cycle_count(cyc_d), .done(dn_d), .timeout(to_d), .match(mt_d));

  pipe_result_monitor #(.GOLDEN_SIG(32'hFFFF_FFFC)) u_gold (
    .clk(clk), .rst_n(rst_n), .clear(clear), .alu_out(alu_a), .signature(sig_g),
    .change_count(chg_g), .cycle_count(cyc_g), .done(dn_g), .timeout(to_g), .match(mt_g));

  pipe_result_monitor #(.MAX_CYCLES(20)) u_to (
    .clk(clk), .rst_n(rst_n), .clear(clear), .alu_out(alu_b), .signature(sig_t),
    .change_count(chg_t), .cycle_count(cyc_t), .done(dn_t), .timeout(to_t), .match(mt_t));

  pipe_result_monitor #(.MAX_CYCLES(12), .STABLE_CYCLES(8)) u_sim (
    .clk(clk), .rst_n(rst_n), .clear(clear), .alu_out(alu_c), .signature(sig_s),
    .change_count(chg_s), .cycle_count(cyc_s), .done(dn_s), .timeout(to_s), .match(mt_s));

  localparam int          RW = 3;
  localparam int          RS = 4;
  localparam int          RM = 40;
  localparam logic [31:0] RG = 32'h0000_0003;

  pipe_result_monitor #(.WARMUP(RW), .STABLE_CYCLES(RS), .MAX_CYCLES(RM), .GOLDEN_SIG(RG)) u_rnd (
    .clk(clk), .rst_n(rst_n), .clear(clear), .alu_out(alu_r), .signature(sig_r),
    .change_count(chg_r), .cycle_count(cyc_r), .done(dn_r), .timeout(to_r), .match(mt_r));

  function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] d);
    logic fb;
    fb = ^(s & 32'h8020_0003);
    return ((s << 1) | {31'd0, fb}) ^ d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural model of u_rnd: counts edges since restart, quiet run length, RUN edges.
  bit          rnd_on = 0;
  bit          m_fin;
  int          m_edges, m_quiet, m_cyc;
  logic [31:0] m_sig, m_prev;
  logic [15:0] m_chg;
  logic        m_done, m_to, m_match;

  task automatic model_edge();
    if (clear) begin
      m_sig = 32'hFFFF_FFFF; m_chg = 0; m_cyc = 0; m_edges = 0; m_quiet = 0;
      m_done = 0; m_to = 0; m_match = 0; m_fin = 0;
    end else if (!m_fin) begin
      if (m_edges < RW) m_edges++;
      else begin
        m_cyc++;
        if (alu_r != m_prev) begin
          m_sig = misr(m_sig, alu_r);
          if (m_chg != 16'hFFFF) m_chg++;
          m_quiet = 0;
        end else m_quiet++;
        if (m_quiet == RS) begin
          m_done = 1; m_match = (m_sig == RG); m_fin = 1;
        end else if (m_cyc == RM) begin
          m_to = 1; m_fin = 1;
        end
      end
    end
    m_prev = alu_r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_on) model_edge();
  endtask

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sig;
    logic [15:0] chg;
    logic [15:0] cyc;
    logic        done;
  } vec_t;

  vec_t tbl[15];

  task automatic run_table(input string tag);
    for (int i = 0; i < 15; i++) begin
      alu_a = tbl[i].alu;
      tick();
      chk($sformatf("%s[%0d].sig", tag, i), sig_d, tbl[i].sig);
      chk($sformatf("%s[%0d].chg", tag, i), chg_d, tbl[i].chg);
      chk($sformatf("%s[%0d].cyc", tag, i), cyc_d, tbl[i].cyc);
      chk($sformatf("%s[%0d].done", tag, i), dn_d, tbl[i].done);
    end
    chk({tag, ".match_gold0"}, mt_d, 1'b0);
    chk({tag, ".match_goldFC"}, mt_g, 1'b1);
    chk({tag, ".timeout"}, to_d, 1'b0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".sig"}, sig_d, 32'hFFFF_FFFF);
    chk({tag, ".chg"}, chg_d, 16'd0);
    chk({tag, ".cyc"}, cyc_d, 16'd0);
    chk({tag, ".done"}, dn_d, 1'b0);
    chk({tag, ".timeout"}, to_d, 1'b0);
    chk({tag, ".match"}, mt_d, 1'b0);
  endtask

  initial begin
    logic [31:0] exp_sig;
    int          fin_wait;

    // Edges 1-5 warmup on 0, then 1, 2, then 2 held until quiet exit on edge 15.
    for (int i = 0; i < 15; i++) begin
      tbl[i].alu  = (i < 5) ? 32'd0 : (i == 5) ? 32'd1 : 32'd2;
      tbl[i].sig  = (i < 6) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC;
      tbl[i].chg  = (i < 5) ? 16'd0 : (i == 5) ? 16'd1 : 16'd2;
      tbl[i].cyc  = (i < 5) ? 16'd0 : 16'(i - 4);
      tbl[i].done = (i == 14);
    end

    // Reset held with a busy bus.
    for (int i = 0; i < 4; i++) begin
      alu_a = $urandom;
      tick();
    end
    chk_idle("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      alu_a = 32'h100 + 32'(i);
      tick();
      chk($sformatf("warm[%0d].sig", i), sig_d, 32'hFFFF_FFFF);
      chk($sformatf("warm[%0d].chg", i), chg_d, 16'd0);
    end

    // Fresh start for the two-change table.
    rst_n = 1'b0;
    alu_a = 32'd0;
    tick();
    rst_n = 1'b1;
    run_table("tbl");
    tick();
    chk("done_sticky", dn_d, 1'b1);
    chk("done_cyc_frozen", cyc_d, 16'd10);

    // Clear out of DONE, then the same program must give the same signature.
    clear = 1'b1;
    alu_a = 32'd0;
    tick();
    clear = 1'b0;
    chk_idle("clear");
    chk("clear.gold_match", mt_g, 1'b0);
    run_table("rerun");

    // Async reset between edges while running.
    clear = 1'b1; alu_a = 32'd0; tick(); clear = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    alu_a = 32'd7; tick();
    alu_a = 32'd9; tick();
    exp_sig = misr(misr(32'hFFFF_FFFF, 32'd7), 32'd9);
    chk("midrun.sig", sig_d, exp_sig);
    chk("midrun.chg", chg_d, 16'd2);
    #2 rst_n = 1'b0;
    #1 chk_idle("async_abort");
    tick();
    rst_n = 1'b1;

    // Timeout with a bus changing every edge.
    clear = 1'b1; alu_b = 32'd0; tick(); clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      alu_b = 32'd1000 + 32'(i);
      tick();
    end
    exp_sig = 32'hFFFF_FFFF;
    for (int i = 1; i <= 20; i++) begin
      alu_b = 32'd2000 + 32'(i);
      exp_sig = misr(exp_sig, alu_b);
      tick();
      if (i == 19) chk("to.edge19.timeout", to_t, 1'b0);
    end
    chk("to.timeout", to_t, 1'b1);
    chk("to.cyc", cyc_t, 16'd20);
    chk("to.done", dn_t, 1'b0);
    chk("to.chg", chg_t, 16'd20);
    chk("to.sig", sig_t, exp_sig);
    for (int i = 0; i < 10; i++) begin
      alu_b = 32'd5000 + 32'(i);
      tick();
    end
    chk("to.frozen.timeout", to_t, 1'b1);
    chk("to.frozen.cyc", cyc_t, 16'd20);
    chk("to.frozen.chg", chg_t, 16'd20);
    chk("to.frozen.sig", sig_t, exp_sig);
    chk("to.frozen.done", dn_t, 1'b0);

    // Quiet exit and budget expiry on the same edge.
    clear = 1'b1; alu_c = 32'd0; tick(); clear = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    for (int i = 1; i <= 12; i++) begin
      alu_c = (i <= 4) ? 32'(10 * i) : 32'd40;
      tick();
      if (i == 11) begin
        chk("sim.edge11.done", dn_s, 1'b0);
        chk("sim.edge11.timeout", to_s, 1'b0);
      end
    end
    chk("sim.done", dn_s, 1'b1);
    chk("sim.timeout", to_s, 1'b0);
    chk("sim.cyc", cyc_s, 16'd12);
    chk("sim.chg", chg_s, 16'd4);

    // Randomized traffic with occasional restarts against the model.
    rnd_on = 1;
    clear = 1'b1; alu_r = 32'd0; tick(); clear = 1'b0;
    fin_wait = 0;
    for (int n = 0; n < 600; n++) begin
      clear = ($urandom_range(0, 79) == 0);
      if (m_fin) begin
        fin_wait++;
        if (fin_wait > 3) begin clear = 1'b1; fin_wait = 0; end
      end
      if ($urandom_range(0, 2) == 0) alu_r = 32'($urandom_range(0, 3));
      tick();
      chk($sformatf("rnd[%0d].sig", n), sig_r, m_sig);
      chk($sformatf("rnd[%0d].chg", n), chg_r, m_chg);
      chk($sformatf("rnd[%0d].cyc", n), cyc_r, 16'(m_cyc));
      chk($sformatf("rnd[%0d].done", n), dn_r, m_done);
      chk($sformatf("rnd[%0d].timeout", n), to_r, m_to);
      chk($sformatf("rnd[%0d].match", n), mt_r, m_match);
    end
    clear = 1'b0;
    rnd_on = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
